// File: rtl/cd_pkg.sv
// Shared constants and types for the multi-channel clock divider.
`timescale 1ns/1ps
package cd_pkg;
    // All-ones control address; the top truncates it to its own ADDR_W.
    localparam logic [31:0] ADDR_CTRL    = '1;
    localparam int          DIV_INIT_DEF = 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cfg_state_e;
endpackage

// File: rtl/cd_channel.sv
// One divider channel: counter, toggling div_clk, tick, and (with CD_SHADOW_EN)
// a shadow divisor that loads at the end of a full period.
`timescale 1ns/1ps
module cd_channel #(
    parameter int               DIV_W    = 8,
    parameter logic [DIV_W-1:0] DIV_INIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [DIV_W-1:0] wdata,
    output logic             div_clk,
    output logic             tick,
    output logic             pend
);
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic             dclk_q, dclk_d;
    logic             at_top;

    assign at_top  = (cnt_q == div_q);
    assign div_clk = dclk_q;
    assign tick    = en && at_top && !dclk_q;

`ifdef CD_SHADOW_EN
    logic [DIV_W-1:0] sh_q, sh_d;
    logic             pend_q, pend_d;
    logic             bnd;

    // Period boundary: last cycle of the high phase, safe point to swap divisor.
    assign bnd  = en && at_top && dclk_q;
    assign pend = pend_q;

    always_comb begin
        sh_d   = sh_q;
        pend_d = pend_q;
        div_d  = div_q;
        if (wr) begin
            if (bnd || !en) begin
                div_d  = wdata;
                pend_d = 1'b0;
            end else begin
                sh_d   = wdata;
                pend_d = 1'b1;
            end
        end else if (pend_q && (bnd || !en)) begin
            div_d  = sh_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= DIV_INIT;
            pend_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            pend_q <= pend_d;
        end
    end
`else
    assign pend = 1'b0;

    always_comb begin
        div_d = div_q;
        if (wr) div_d = wdata;
    end
`endif

    always_comb begin
        cnt_d  = cnt_q;
        dclk_d = dclk_q;
        if (!en) begin
            cnt_d  = '0;
            dclk_d = 1'b0;
        end else if (at_top) begin
            cnt_d  = '0;
            dclk_d = ~dclk_q;
        end else begin
            cnt_d  = cnt_q + DIV_W'(1);
        end
`ifndef CD_SHADOW_EN
        // Direct load restarts the channel so the new period starts cleanly.
        if (wr) begin
            cnt_d  = '0;
            dclk_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            dclk_q <= 1'b0;
            div_q  <= DIV_INIT;
        end else begin
            cnt_q  <= cnt_d;
            dclk_q <= dclk_d;
            div_q  <= div_d;
        end
    end
endmodule

// File: rtl/cd_multi.sv
// Multi-channel clock divider top: config handshake FSM, address decode, enable mask.
// Optional feature macro: CD_SHADOW_EN (shadowed, period-aligned divisor updates).
`timescale 1ns/1ps
module cd_multi
    import cd_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DIV_W    = 8,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int DIV_INIT = DIV_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_valid,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_data,
    output logic              c_ready,
    output logic [NCH-1:0]    div_clk,
    output logic [NCH-1:0]    tick,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_CTRL[ADDR_W-1:0];

    cfg_state_e     state_q, state_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [NCH-1:0] pend;
    logic           accept;

    assign c_ready = (state_q == IDLE);
    assign accept  = c_valid && c_ready;
    assign busy    = |pend;

    // A held c_valid yields one write: HOLD waits for c_valid to drop.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE:    if (c_valid) state_d = HOLD;
            HOLD:    if (!c_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept && c_addr == CTRL_A) mask_d = c_data[NCH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [ADDR_W-1:0] CH_A = ADDR_W'(i);
        cd_channel #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_W'(DIV_INIT))
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (mask_q[i]),
            .wr      (accept && c_addr == CH_A),
            .wdata   (c_data[DIV_W-1:0]),
            .div_clk (div_clk[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end
endmodule
